// File: rtl/apb_burst_master_pkg.sv
// apb_burst_master_pkg: shared FSM state, response/burst encodings and size clipping for the APB burst master (no ports)
package apb_burst_master_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_BEAT, SETUP, ACCESS, RESP} apb_mst_state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  function automatic logic [2:0] clip_size(input logic [2:0] size, input logic [2:0] max_size);
    return size > max_size ? max_size : size;
  endfunction
endpackage

// File: rtl/apb_burst_master_if.sv
// apb_burst_master_if: burst command, write-data, read-return, write-response and APB4 signals (master = burst master view, slave = environment view)
interface apb_burst_master_if #(
  parameter int ID_WIDTH = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } addr_info_t;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_write;
  logic [ID_WIDTH-1:0] cmd_id;
  addr_info_t cmd_info;
  logic wd_valid;
  logic wd_ready;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [DATA_WIDTH/8-1:0] wd_strb;
  logic rd_valid;
  logic rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0] rd_resp;
  logic rd_last;
  logic [ID_WIDTH-1:0] rd_id;
  logic b_valid;
  logic b_ready;
  logic [1:0] b_resp;
  logic [ID_WIDTH-1:0] b_id;
  logic [ADDR_WIDTH-1:0] paddr;
  logic psel;
  logic penable;
  logic pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic pslverr;
  modport master (
    input cmd_valid, cmd_write, cmd_id, cmd_info, wd_valid, wd_data, wd_strb, rd_ready, b_ready, pready, prdata, pslverr,
    output cmd_ready, wd_ready, rd_valid, rd_data, rd_resp, rd_last, rd_id, b_valid, b_resp, b_id,
    output paddr, psel, penable, pwrite, pwdata, pstrb
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_id, cmd_info, wd_valid, wd_data, wd_strb, rd_ready, b_ready, pready, prdata, pslverr,
    input cmd_ready, wd_ready, rd_valid, rd_data, rd_resp, rd_last, rd_id, b_valid, b_resp, b_id,
    input paddr, psel, penable, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/apb_burst_master_addr_gen.sv
// apb_addr_gen: combinational next beat address (in: addr, size, burst; out: next_addr), FIXED holds, everything else increments by the clipped size
module apb_addr_gen import apb_burst_master_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));
  assign next_addr = burst == BURST_FIXED ? addr : addr + (ADDR_WIDTH'(1) << clip_size(size, MAX_SIZE));
endmodule

// File: rtl/apb_burst_master.sv
// apb_burst_master: splits one burst command into len+1 APB4 transfers (ports: clk, rst, bus = cmd/wd/rd/b/APB via apb_burst_master_if.master)
module apb_burst_master import apb_burst_master_pkg::*; #(
  parameter int ID_WIDTH = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  apb_burst_master_if.master bus
);
  apb_mst_state_t state;
  logic [7:0] cnt;
  logic [2:0] size_q;
  logic [1:0] burst_q;
  logic [1:0] err;
  logic [1:0] err_n;
  logic [ID_WIDTH-1:0] id_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic beat_ok;
  assign err_n = err | (bus.pslverr ? RESP_SLVERR : RESP_OKAY);
  // a read beat may only start once the output register is free or being emptied this cycle
  assign beat_ok = bus.pwrite ? bus.wd_valid : (!bus.rd_valid || bus.rd_ready);
  assign bus.wd_ready = state == WAIT_BEAT && bus.pwrite && bus.wd_valid;
  apb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_addr_gen (
    .addr(bus.paddr),
    .size(size_q),
    .burst(burst_q),
    .next_addr(next_addr)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      size_q <= '0;
      burst_q <= '0;
      err <= RESP_OKAY;
      id_q <= '0;
      bus.cmd_ready <= 1'b1;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_resp <= '0;
      bus.rd_last <= 1'b0;
      bus.rd_id <= '0;
      bus.b_valid <= 1'b0;
      bus.b_resp <= '0;
      bus.b_id <= '0;
      bus.paddr <= '0;
      bus.psel <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite <= 1'b0;
      bus.pwdata <= '0;
      bus.pstrb <= '0;
    end else begin
      if (bus.rd_valid && bus.rd_ready) bus.rd_valid <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          bus.paddr <= bus.cmd_info.addr;
          cnt <= bus.cmd_info.len;
          size_q <= bus.cmd_info.size;
          burst_q <= bus.cmd_info.burst;
          id_q <= bus.cmd_id;
          bus.pwrite <= bus.cmd_write;
          err <= RESP_OKAY;
          bus.cmd_ready <= 1'b0;
          state <= WAIT_BEAT;
        end
        WAIT_BEAT: if (beat_ok) begin
          if (bus.pwrite) begin
            bus.pwdata <= bus.wd_data;
            bus.pstrb <= bus.wd_strb;
          end else bus.pstrb <= '0;
          bus.psel <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          bus.penable <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: if (bus.pready) begin
          bus.psel <= 1'b0;
          bus.penable <= 1'b0;
          err <= err_n;
          if (!bus.pwrite) begin
            bus.rd_valid <= 1'b1;
            bus.rd_data <= bus.prdata;
            bus.rd_resp <= bus.pslverr ? RESP_SLVERR : RESP_OKAY;
            bus.rd_last <= cnt == 8'd0;
            bus.rd_id <= id_q;
          end
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
            bus.paddr <= next_addr;
            state <= WAIT_BEAT;
          end else if (bus.pwrite) begin
            bus.b_valid <= 1'b1;
            bus.b_resp <= err_n;
            bus.b_id <= id_q;
            state <= RESP;
          end else begin
            bus.cmd_ready <= 1'b1;
            state <= IDLE;
          end
        end
        RESP: if (bus.b_ready) begin
          bus.b_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/apb_burst_master.md
Name: apb_burst_master

Overview:
- Downstream APB stage of the AXI2APB bridge.
- Accepts one burst command (addr_info_t, direction, ID) from the bridge engine and splits it into len+1 single APB4 transfers.
- Write data is taken from the write-data FIFO. Read data and read responses go to the read-return FIFO.
- Produces one merged write response per write burst.

Parameters:
- ID_WIDTH, 1, width of the transaction ID carried through to responses
- ADDR_WIDTH, 32, APB/AXI address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  block idle, command accepted on valid&&ready
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_id  in  ID_WIDTH  transaction ID
- cmd_info  in  addr_info_t  addr/len/size/burst
- wd_valid  in  1  write beat available
- wd_ready  out  1  write beat consumed
- wd_data  in  DATA_WIDTH  write data
- wd_strb  in  DATA_WIDTH/8  byte enables
- rd_valid  out  1  read beat valid
- rd_ready  in  1  read-return FIFO can accept
- rd_data  out  DATA_WIDTH  read data
- rd_resp  out  2  OKAY/SLVERR per beat
- rd_last  out  1  final beat of burst
- rd_id  out  ID_WIDTH  ID of burst
- b_valid  out  1  write response valid
- b_ready  in  1  write response accepted
- b_resp  out  2  merged write response
- b_id  out  ID_WIDTH  ID of burst
- paddr  out  ADDR_WIDTH  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB4 strobe; all-zero on reads
- pready  in  1  slave ready
- prdata  in  DATA_WIDTH  slave read data
- pslverr  in  1  slave error

Behaviour:
- Reset (async, immediate):
  - States: FSM=IDLE.
  - Outputs: all outputs 0 except cmd_ready=1.
  - Internal state: beat counter 0, error accumulator OKAY.
  - A reset asserted mid-burst drops the burst; no response is issued.
- FSM states: IDLE, WAIT_BEAT, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch info/id/write, beat counter=len, err=OKAY.
  - Next state is WAIT_BEAT.
- WAIT_BEAT:
  - Write: requires wd_valid.
  - Read: requires rd_valid==0, or rd_valid&&rd_ready this cycle.
  - When the condition holds: go to SETUP next cycle. Write data and strobe are registered into pwdata/pstrb; wd_ready is pulsed for exactly that cycle.
- SETUP: psel=1, penable=0, paddr/pwrite stable. Always exactly 1 cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1; held until pready.
  - On pready: err |= pslverr (2'b10).
  - Read: rd_valid=1 next cycle with rd_data=prdata, rd_resp={pslverr,1'b0}, rd_last=(counter==0).
- After the ACCESS pready cycle:
  - If counter!=0: decrement, compute next address, go to WAIT_BEAT.
  - If counter==0: a write goes to RESP; a read goes to IDLE.
- RESP: b_valid=1, b_resp=err; held until b_ready, then IDLE.
- Minimum beat cost: 3 cycles (WAIT_BEAT, SETUP, ACCESS) with zero-wait slaves. A zero-wait single-beat write has 4-cycle command-to-b_valid latency.
- Read output register:
  - rd_valid stays high until rd_ready.
  - A new read SETUP never starts while an unaccepted beat is held, so no beat is ever lost.
- Address generation:
  - FIXED (2'b00): address unchanged.
  - INCR (2'b01): addr + (1<<size), ADDR_WIDTH wrap-around modulo 2^ADDR_WIDTH.
  - WRAP (2'b10) and reserved (2'b11): treated as INCR.
  - size greater than log2(DATA_WIDTH/8) is clipped to the maximum.
- pslverr is ignored when pready=0.
- psel/penable drop to 0 in every state other than SETUP/ACCESS.
- pwdata/pstrb hold their last value outside writes.
- A cmd_valid during a burst is not accepted (cmd_ready=0).

Decomposition:
- Add to bridge_utils:
  - apb_mst_state_t enum {IDLE, WAIT_BEAT, SETUP, ACCESS, RESP}.
  - Constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Constants BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
- One sub-module: apb_addr_gen, combinational next-address from addr/size/burst, shared with the AXI reader's address tracking.

Test Plan:
- Single write: addr 0x1000, len 0, size 2, INCR, data 0xDEADBEEF, strb 0xF, pready=1 -> one APB write; paddr=0x1000, pwdata=0xDEADBEEF, pstrb=0xF; b_valid with b_resp=00.
- INCR read: len 3, size 2 from 0x2000, slave returns 0x11/0x22/0x33/0x44 -> paddr 0x2000/0x2004/0x2008/0x200C; four rd beats in order; rd_last only on 0x44.
- FIXED write: len 2 at 0x3000, slave pready delayed 2 cycles each beat -> three writes all at 0x3000; penable held through wait states.
- Error merge: 4-beat write, pslverr on beat 2 only -> single b_resp=10. 4-beat read, same -> rd_resp=10 only on beat 2.
- Backpressure: read len 1 with rd_ready=0 for 5 cycles after beat 0 -> no second SETUP until beat 0 accepted; beat 0 data stable. Write with wd_valid gap of 4 cycles -> psel stays 0 during the gap.
- Mid-burst reset: assert rst during ACCESS of beat 1 of 4 -> psel/penable/b_valid/rd_valid drop to 0 asynchronously; cmd_ready=1 after release; a fresh command completes normally.
